// File: rtl/sme_multi.sv
// sme_multi: string-match engine; stores one string, then searches it for each loaded pattern.
// Latency: busy rises the cycle after the last pattern element; the search takes at most (L+1)*M cycles, then a one-cycle valid.
// Backpressure: none; a new isstring/ispattern burst aborts a running search (no valid pulse).
//
// Ports:
//   clk, reset_n           single clock, asynchronous active-low reset
//   chardata[7:0]          character byte, qualified by isstring / ispattern
//   isstring               chardata is the next string character (has priority over ispattern)
//   ispattern              chardata is the next pattern element ('.', '^', '$' are meta)
//   busy                   search in progress
//   valid                  one-cycle pulse, match/match_index are the result
//   match, match_index     result of the last completed search, held until the next valid
//
// Build option: define SME_NOCASE_EN to make literal compares case-insensitive for A-Z/a-z.
module sme_multi #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int IDX_W   = $clog2(STR_MAX + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       chardata,
   input  logic             isstring,
   input  logic             ispattern,
   output logic             busy,
   output logic             valid,
   output logic             match,
   output logic [IDX_W-1:0] match_index
);

   localparam int AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
   localparam int MW = $clog2(PAT_MAX + 1);
   localparam int KW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

   typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

   state_t           state_q;
   logic [7:0]       str_q [STR_MAX];
   logic [7:0]       pat_q [PAT_MAX];
   logic [IDX_W-1:0] len_q;      // stored string length L
   logic [MW-1:0]    m_q;        // stored pattern length M
   logic [IDX_W-1:0] s_q;        // candidate start
   logic [IDX_W-1:0] p_q;        // string pointer within the candidate
   logic [KW-1:0]    k_q;        // pattern element under test
   logic             busy_q, valid_q, match_q;
   logic [IDX_W-1:0] idx_q;

   logic [7:0]       elem_d, cur_ch_d, prev_ch_d;
   logic [AW-1:0]    p_m1_d;
   logic             in_str_d, lit_eq_d, elem_ok_d, k_last_d;
   logic [IDX_W-1:0] p_nxt_d;

`ifdef SME_NOCASE_EN
   function automatic logic [7:0] fold(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
   endfunction
`endif

   // Evaluate pattern element k at pointer p. Reads are guarded so an
   // out-of-range pointer never addresses the string array.
   always_comb begin
      elem_d    = pat_q[k_q];
      in_str_d  = (p_q < len_q);
      cur_ch_d  = in_str_d ? str_q[p_q[AW-1:0]] : 8'h00;
      // p <= L <= STR_MAX, so p-1 fits in AW bits whenever p > 0
      p_m1_d    = p_q[AW-1:0] - AW'(1);
      prev_ch_d = (p_q != '0) ? str_q[p_m1_d] : 8'h00;
`ifdef SME_NOCASE_EN
      lit_eq_d  = (fold(cur_ch_d) == fold(elem_d));
`else
      lit_eq_d  = (cur_ch_d == elem_d);
`endif
      elem_ok_d = 1'b0;
      p_nxt_d   = p_q;
      case (elem_d)
         8'h2E: begin
            elem_ok_d = in_str_d;
            p_nxt_d   = p_q + IDX_W'(1);
         end
         8'h5E: elem_ok_d = (p_q == '0) || (prev_ch_d == 8'h20);
         8'h24: elem_ok_d = (p_q == len_q) || (cur_ch_d == 8'h20);
         default: begin
            elem_ok_d = in_str_d && lit_eq_d;
            p_nxt_d   = p_q + IDX_W'(1);
         end
      endcase
      k_last_d = (MW'(k_q) == (m_q - MW'(1)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         m_q     <= '0;
         s_q     <= '0;
         p_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
         idx_q   <= '0;
         for (int i = 0; i < STR_MAX; i++) str_q[i] <= '0;
         for (int i = 0; i < PAT_MAX; i++) pat_q[i] <= '0;
      end else begin
         valid_q <= 1'b0;
         if (isstring) begin
            // A load always wins over a running search; it restarts L on a new burst.
            busy_q <= 1'b0;
            if (state_q != LOAD_STR) begin
               str_q[0] <= chardata;
               len_q    <= IDX_W'(1);
               state_q  <= LOAD_STR;
            end else if (len_q < IDX_W'(STR_MAX)) begin
               str_q[len_q[AW-1:0]] <= chardata;
               len_q                <= len_q + IDX_W'(1);
            end
         end else if (ispattern) begin
            busy_q <= 1'b0;
            if (state_q != LOAD_PAT) begin
               pat_q[0] <= chardata;
               m_q      <= MW'(1);
               state_q  <= LOAD_PAT;
            end else if (m_q < MW'(PAT_MAX)) begin
               pat_q[m_q[KW-1:0]] <= chardata;
               m_q                <= m_q + MW'(1);
            end
         end else begin
            case (state_q)
               LOAD_STR: state_q <= IDLE;
               LOAD_PAT: begin
                  state_q <= SEARCH;
                  busy_q  <= 1'b1;
                  s_q     <= '0;
                  p_q     <= '0;
                  k_q     <= '0;
               end
               SEARCH: begin
                  if (m_q == '0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b1;
                     match_q <= 1'b1;
                     idx_q   <= '0;
                  end else if (elem_ok_d) begin
                     if (k_last_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        match_q <= 1'b1;
                        idx_q   <= s_q;
                     end else begin
                        k_q <= k_q + KW'(1);
                        p_q <= p_nxt_d;
                     end
                  end else if (s_q == len_q) begin
                     // last candidate (s == L) failed: no match, s never exceeds L
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b1;
                     match_q <= 1'b0;
                     idx_q   <= '0;
                  end else begin
                     s_q <= s_q + IDX_W'(1);
                     p_q <= s_q + IDX_W'(1);
                     k_q <= '0;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy        = busy_q;
   assign valid       = valid_q;
   assign match       = match_q;
   assign match_index = idx_q;

endmodule

// File: tb/tb_sme_multi.sv
// tb_sme_multi: directed self-checking bench for sme_multi.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_sme_multi;
   localparam int STR_MAX = 32;
   localparam int PAT_MAX = 8;
   localparam int IDX_W   = $clog2(STR_MAX + 1);

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [7:0]       chardata = 8'h00;
   logic             isstring = 1'b0;
   logic             ispattern = 1'b0;
   logic             busy, valid, match;
   logic [IDX_W-1:0] match_index;

   int total = 0;
   int bad = 0;
   int vld_cnt = 0;

   always #5 clk = ~clk;

   // counts valid pulses independently of the checking flow
   always @(negedge clk) if (valid === 1'b1) vld_cnt++;

   sme_multi #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .chardata    (chardata),
      .isstring    (isstring),
      .ispattern   (ispattern),
      .busy        (busy),
      .valid       (valid),
      .match       (match),
      .match_index (match_index)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string s, input bit as_str);
      for (int i = 0; i < s.len(); i++) begin
         chardata  = s[i];
         isstring  = as_str;
         ispattern = !as_str;
         tick();
      end
      isstring  = 1'b0;
      ispattern = 1'b0;
   endtask

   task automatic send_alpha(input int n);
      for (int i = 0; i < n; i++) begin
         chardata = 8'h61 + 8'(i % 26);
         isstring = 1'b1;
         tick();
      end
      isstring = 1'b0;
   endtask

   // Called with ispattern already low; expects exactly one valid pulse since v0.
   task automatic wait_result(input string tag, input logic exp_m, input logic [IDX_W-1:0] exp_i, input int v0);
      bit seen = 0;
      tick();
      check_eq({tag, "_busy"}, busy, 1);
      for (int c = 0; c < 300 && !seen; c++) begin
         if (valid === 1'b1) seen = 1;
         else tick();
      end
      check_eq({tag, "_done"}, seen, 1);
      check_eq({tag, "_match"}, match, exp_m);
      check_eq({tag, "_index"}, match_index, exp_i);
      tick();
      check_eq({tag, "_after"}, {valid, busy}, 0);
      check_eq({tag, "_pulses"}, vld_cnt - v0, 1);
   endtask

   task automatic run_pat(input string tag, input string pat, input logic exp_m, input logic [IDX_W-1:0] exp_i);
      int v0;
      v0 = vld_cnt;
      send(pat, 1'b0);
      wait_result(tag, exp_m, exp_i, v0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int v0;
      tick();
      tick();
      check_eq("rst_valid", valid, 0);
      check_eq("rst_match", match, 0);
      check_eq("rst_index", match_index, 0);
      check_eq("rst_busy", busy, 0);
      reset_n = 1'b1;
      tick();

      send("hello world", 1'b1);
      run_pat("wor", "wor", 1'b1, 6);
      run_pat("anc_w", "^w", 1'b1, 6);
      run_pat("o_end", "o$", 1'b1, 4);
      run_pat("l_dot_o", "l.o", 1'b1, 2);
      run_pat("xyz", "xyz", 1'b0, 0);

      send("ab", 1'b1);
      run_pat("ab_empty", "^$", 1'b0, 0);
      run_pat("ab_b_end", "b$", 1'b1, 1);

      do_reset();
      run_pat("nul_str", "^$", 1'b1, 0);

      // 40 characters offered, only the first 32 are kept
      send_alpha(40);
      run_pat("sat_f_end", "f$", 1'b1, 31);
      run_pat("sat_zab", "zab", 1'b1, 25);

      // abort a long search by starting a new pattern
      v0 = vld_cnt;
      send("zz", 1'b0);
      tick();
      tick();
      tick();
      check_eq("abort_busy_pre", busy, 1);
      chardata  = "c";
      ispattern = 1'b1;
      tick();
      check_eq("abort_busy_fall", busy, 0);
      chardata = "d";
      tick();
      ispattern = 1'b0;
      wait_result("abort_cd", 1'b1, 2, v0);

      // reset mid-search clears outputs at once and discards the string
      v0 = vld_cnt;
      send("zz", 1'b0);
      tick();
      tick();
      reset_n = 1'b0;
      #2;
      check_eq("mid_rst_outs", {busy, valid, match, 32'(match_index)}, 0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check_eq("mid_rst_pulses", vld_cnt - v0, 0);
      run_pat("post_rst_empty", "^$", 1'b1, 0);
      run_pat("post_rst_a", "a", 1'b0, 0);

      send("hello WORLD", 1'b1);
`ifdef SME_NOCASE_EN
      run_pat("nocase", "wor", 1'b1, 6);
`else
      run_pat("exactcase", "wor", 1'b0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
